// File: rtl/itlb_refill_walker.sv
// Instruction-TLB refill walker: on a user-mode iTLB miss, fetches one PTE from a
// single-level page table and either fills the iTLB or raises a page fault.
module itlb_refill_walker #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int PTE_SHIFT      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        supervisor_mode,
  input  logic        tlb_miss,
  input  logic [31:0] miss_address,
  input  logic [31:0] ptbr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        tlb_write,
  output logic [19:0] reg_logic_page,
  output logic [7:0]  reg_physical_page,
  output logic        busy,
  output logic        page_fault,
  output logic [31:0] fault_address,
  output logic [1:0]  fault_cause
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] FILL  = 3'd3;
  localparam logic [2:0] FAULT = 3'd4;
  localparam logic [2:0] DRAIN = 3'd5;
  localparam logic [2:0] HOLD  = 3'd6;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [19:0]   vpn_reg;
  logic [7:0]    ppn_reg, ppn_next;
  logic [31:0]   addr_reg;
  logic [31:0]   fault_addr_reg;
  logic [1:0]    cause_reg, cause_next;
  logic          accept;
  logic [31:0]   pte_addr;

  // Only V, U and the PPN byte of the PTE carry meaning.
  logic unused_pte_bits;
  assign unused_pte_bits = ^mem_rdata[29:8];

  assign accept   = (state_reg == IDLE) && tlb_miss && !supervisor_mode && !flush;
  assign pte_addr = ptbr + ({12'd0, miss_address[31:12]} << PTE_SHIFT);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ppn_next   = ppn_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = REQ;
      end
      REQ: begin
        cnt_next = '0;
        // Once granted, the read is in flight and its data must be drained.
        if (mem_gnt)    state_next = flush ? DRAIN : WAIT;
        else if (flush) state_next = IDLE;
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_next = IDLE;
          end else if (!mem_rdata[31]) begin
            state_next = FAULT;
            cause_next = 2'b01;
          end else if (!mem_rdata[30]) begin
            state_next = FAULT;
            cause_next = 2'b10;
          end else begin
            state_next = FILL;
            ppn_next   = mem_rdata[7:0];
          end
        end else if (flush) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = FAULT;
          cause_next = 2'b11;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FILL:  state_next = HOLD;
      FAULT: state_next = HOLD;
      HOLD:  state_next = IDLE;
      DRAIN: begin
        if (mem_rvalid || cnt_reg == CNT_LAST) state_next = IDLE;
        else                                   cnt_next   = cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      vpn_reg        <= '0;
      ppn_reg        <= '0;
      addr_reg       <= '0;
      fault_addr_reg <= '0;
      cause_reg      <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ppn_reg   <= ppn_next;
      cause_reg <= cause_next;
      // Request context is captured once; ptbr/miss_address may move afterwards.
      if (accept) begin
        vpn_reg        <= miss_address[31:12];
        fault_addr_reg <= miss_address;
        addr_reg       <= pte_addr;
      end
    end
  end

  assign mem_req           = (state_reg == REQ);
  assign mem_addr          = addr_reg;
  assign tlb_write         = (state_reg == FILL);
  assign reg_logic_page    = vpn_reg;
  assign reg_physical_page = ppn_reg;
  assign busy              = (state_reg != IDLE);
  assign page_fault        = (state_reg == FAULT);
  assign fault_address     = fault_addr_reg;
  assign fault_cause       = cause_reg;

endmodule

// File: tb/tb_itlb_refill_walker.sv
// Directed bench for itlb_refill_walker: fills, faults, timeout, flush, supervisor, reset.
module tb_itlb_refill_walker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        supervisor_mode = 1'b0;
  logic        tlb_miss = 1'b0;
  logic [31:0] miss_address = '0;
  logic [31:0] ptbr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        tlb_write;
  logic [19:0] reg_logic_page;
  logic [7:0]  reg_physical_page;
  logic        busy;
  logic        page_fault;
  logic [31:0] fault_address;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int pf_cnt = 0;
  int wr0, pf0;

  itlb_refill_walker #(.TIMEOUT_CYCLES(64), .PTE_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .supervisor_mode(supervisor_mode),
    .tlb_miss(tlb_miss), .miss_address(miss_address), .ptbr(ptbr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .tlb_write(tlb_write),
    .reg_logic_page(reg_logic_page), .reg_physical_page(reg_physical_page),
    .busy(busy), .page_fault(page_fault), .fault_address(fault_address),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  // Strobe widths are measured on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (tlb_write)  wr_cnt++;
    if (page_fault) pf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_wr"}, tlb_write, 0);
    chk({tag, "_pf"}, page_fault, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_lp"}, reg_logic_page, 0);
    chk({tag, "_pp"}, reg_physical_page, 0);
    chk({tag, "_fa"}, fault_address, 0);
    chk({tag, "_fc"}, fault_cause, 0);
  endtask

  // Present a miss for one cycle; on return the walker should be in REQ.
  task automatic miss(input logic [31:0] a, input logic [31:0] base);
    miss_address = a;
    ptbr = base;
    tlb_miss = 1'b1;
    tick();
    tlb_miss = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata = d;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("idle");

    // Valid fill: vpn 0x00403, 0x403<<2 = 0x100C, + 0x00010000 = 0x0001100C
    wr0 = wr_cnt; pf0 = pf_cnt;
    miss(32'h00403ABC, 32'h00010000);
    chk("fill_req", mem_req, 1);
    chk("fill_addr", mem_addr, 32'h0001100C);
    chk("fill_busy", busy, 1);
    grant();
    chk("fill_req_drop", mem_req, 0);
    respond(32'hC0000055);
    chk("fill_wr", tlb_write, 1);
    chk("fill_lp", reg_logic_page, 20'h00403);
    chk("fill_pp", reg_physical_page, 8'h55);
    tick();
    chk("hold_wr", tlb_write, 0);
    chk("hold_busy", busy, 1);
    tick();
    chk("fill_idle", busy, 0);
    chk("fill_wr_cnt", wr_cnt - wr0, 1);
    chk("fill_pf_cnt", pf_cnt - pf0, 0);

    // V=0 fault; tlb_miss during HOLD must be ignored
    wr0 = wr_cnt; pf0 = pf_cnt;
    miss(32'h00403ABC, 32'h00010000);
    grant();
    respond(32'h40000012);
    chk("v0_pf", page_fault, 1);
    chk("v0_cause", fault_cause, 2'b01);
    chk("v0_fa", fault_address, 32'h00403ABC);
    tick();
    tlb_miss = 1'b1;
    miss_address = 32'h00ABC000;
    tick();
    tlb_miss = 1'b0;
    chk("hold_ignore_busy", busy, 0);
    chk("hold_ignore_req", mem_req, 0);
    chk("v0_wr_cnt", wr_cnt - wr0, 0);
    chk("v0_pf_cnt", pf_cnt - pf0, 1);

    // U=0 fault with stalled grant; 0xFFFFF000 + (0x12345<<2) wraps to 0x00047D14
    pf0 = pf_cnt;
    miss(32'h12345678, 32'hFFFFF000);
    ptbr = 32'h00000000;
    miss_address = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h00047D14);
    end
    grant();
    tick();
    respond(32'h80000012);
    chk("u0_pf", page_fault, 1);
    chk("u0_cause", fault_cause, 2'b10);
    chk("u0_fa", fault_address, 32'h12345678);
    tick();
    tick();
    chk("u0_pf_cnt", pf_cnt - pf0, 1);

    // Timeout after 64 WAIT cycles; late data dropped
    wr0 = wr_cnt; pf0 = pf_cnt;
    miss(32'h00403ABC, 32'h00010000);
    grant();
    for (int i = 0; i < 63; i++) tick();
    chk("to_early_pf", page_fault, 0);
    chk("to_early_busy", busy, 1);
    tick();
    chk("to_pf", page_fault, 1);
    chk("to_cause", fault_cause, 2'b11);
    respond(32'hC00000EE);
    respond(32'hC00000EE);
    chk("late_idle", busy, 0);
    chk("late_wr_cnt", wr_cnt - wr0, 0);
    chk("to_pf_cnt", pf_cnt - pf0, 1);

    // Clean walk after timeout
    wr0 = wr_cnt;
    miss(32'h00801000, 32'h00010000);
    chk("after_addr", mem_addr, 32'h00012004);
    grant();
    respond(32'hC00000AA);
    chk("after_wr", tlb_write, 1);
    chk("after_lp", reg_logic_page, 20'h00801);
    chk("after_pp", reg_physical_page, 8'hAA);
    tick();
    tick();
    chk("after_wr_cnt", wr_cnt - wr0, 1);

    // Flush in WAIT, valid PTE 3 cycles later goes to waste
    wr0 = wr_cnt; pf0 = pf_cnt;
    miss(32'h00403ABC, 32'h00010000);
    grant();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy", busy, 1);
    tick();
    tick();
    chk("drain_busy2", busy, 1);
    respond(32'hC0000077);
    chk("drain_idle", busy, 0);
    tick();
    chk("drain_wr_cnt", wr_cnt - wr0, 0);
    chk("drain_pf_cnt", pf_cnt - pf0, 0);

    // Flush in REQ without grant: no request issued
    miss(32'h00403ABC, 32'h00010000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("freq_idle", busy, 0);
    chk("freq_req", mem_req, 0);

    // Supervisor misses ignored
    supervisor_mode = 1'b1;
    miss(32'h00403ABC, 32'h00010000);
    chk("sup_req", mem_req, 0);
    chk("sup_busy", busy, 0);
    supervisor_mode = 1'b0;

    // Reset during WAIT, outstanding data afterwards ignored
    wr0 = wr_cnt;
    miss(32'h00403ABC, 32'h00010000);
    grant();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst_wait");
    respond(32'hC0000033);
    chk("rst_after_busy", busy, 0);
    chk("rst_after_wr_cnt", wr_cnt - wr0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
